// File: rtl/wrr4_pkg.sv
// Shared types and PMTU helpers for the WRR4 requester/dispatcher.
package wrr4_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

  localparam logic [2:0] MTU_256  = 3'd0;
  localparam logic [2:0] MTU_512  = 3'd1;
  localparam logic [2:0] MTU_1024 = 3'd2;
  localparam logic [2:0] MTU_2048 = 3'd3;
  localparam logic [2:0] MTU_4096 = 3'd4;
  localparam logic [2:0] MAX_CODE = MTU_4096;

  function automatic logic [2:0] clamp_code(input logic [2:0] code);
    return (code > MAX_CODE) ? MAX_CODE : code;
  endfunction

  function automatic logic [4:0] mtu2wt(input logic [2:0] code);
    return 5'd16 >> clamp_code(code);
  endfunction

  // Packet bytes are 256 << code; beat_bytes is an elaboration constant.
  function automatic logic [6:0] mtu2beats(input logic [2:0] code, input int beat_bytes);
    int bytes;
    bytes = 256 << clamp_code(code);
    return 7'(bytes / beat_bytes);
  endfunction

endpackage

// File: rtl/wrr4_pend_cnt.sv
// Saturating pending-packet counter with a sticky overflow flag.
module wrr4_pend_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == '1) ovf_d = 1'b1;
      else             cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/wrr4_req_disp.sv
// Requester side of the 4-way WRR handshake: advertises pending channels with
// PMTU-derived weights, then streams the granted channel's packet beat by beat.
module wrr4_req_disp
  import wrr4_pkg::*;
#(
  parameter int BEAT_BYTES  = 64,
  parameter int PEND_W      = 8,
  parameter int CNT_W       = 32,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       pkt_push,
  input  logic [2:0]       mtu0,
  input  logic [2:0]       mtu1,
  input  logic [2:0]       mtu2,
  input  logic [2:0]       mtu3,
  output logic             req_val,
  output logic             req0,
  output logic             req1,
  output logic             req2,
  output logic             req3,
  output logic [4:0]       wt0,
  output logic [4:0]       wt1,
  output logic [4:0]       wt2,
  output logic [4:0]       wt3,
  input  logic             gnt_val,
  input  logic             gnt0,
  input  logic             gnt1,
  input  logic             gnt2,
  input  logic             gnt3,
  output logic             gnt_busy,
  output logic             tx_val,
  input  logic             tx_rdy,
  output logic [1:0]       tx_ch,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic             gnt_err,
  output logic [3:0]       pend_ovf,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic [CNT_W-1:0] gnt_cnt2,
  output logic [CNT_W-1:0] gnt_cnt3
);

  localparam int TMR_W = $clog2(GNT_TIMEOUT) + 1;

  state_t           state_q;
  logic [3:0]       req_mask_q;
  logic [1:0]       ch_q;
  logic [6:0]       nbeats_q;
  logic [6:0]       beat_q;
  logic [TMR_W-1:0] timer_q;
  logic             gnt_err_q;

  logic [2:0]        mtu [4];
  logic [PEND_W-1:0] pend [4];
  logic [4:0]        wt [4];
  logic [3:0]        pend_nz;
  logic [3:0]        dec;
  logic [3:0]        gnt_vec;
  logic [1:0]        gnt_idx;
  logic              gnt_onehot, gnt_legal, sending, last_beat, eop_hs;

  assign mtu[0]    = mtu0;
  assign mtu[1]    = mtu1;
  assign mtu[2]    = mtu2;
  assign mtu[3]    = mtu3;
  assign gnt_vec   = {gnt3, gnt2, gnt1, gnt0};
  assign sending   = (state_q == SEND);
  assign last_beat = (beat_q == nbeats_q - 7'd1);
  assign eop_hs    = sending && last_beat && tx_rdy;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;

      assign dec[gi] = eop_hs && (ch_q == 2'(gi));

      wrr4_pend_cnt #(.W(PEND_W)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pkt_push[gi]),
        .dec_i (dec[gi]),
        .cnt_o (pend[gi]),
        .ovf_o (pend_ovf[gi])
      );

      assign pend_nz[gi] = (pend[gi] != '0);
      assign wt[gi]      = (state_q == REQ) ? mtu2wt(mtu[gi]) : 5'd0;

      always_ff @(posedge clk) begin
        if (rst)          cnt_q <= '0;
        else if (dec[gi]) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  endgenerate

  always_comb begin
    gnt_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_vec[i]) gnt_idx = 2'(i);
    end
  end

  // A grant is only honoured for a channel advertised in the most recent REQ.
  assign gnt_onehot = (gnt_vec != 4'd0) && ((gnt_vec & (gnt_vec - 4'd1)) == 4'd0);
  assign gnt_legal  = gnt_onehot && ((gnt_vec & req_mask_q) != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_mask_q <= '0;
      ch_q       <= '0;
      nbeats_q   <= '0;
      beat_q     <= '0;
      timer_q    <= '0;
      gnt_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|pend_nz) state_q <= REQ;
        REQ: begin
          req_mask_q <= pend_nz;
          timer_q    <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (gnt_val) begin
            if (gnt_legal) begin
              ch_q     <= gnt_idx;
              nbeats_q <= mtu2beats(mtu[gnt_idx], BEAT_BYTES);
              beat_q   <= '0;
              state_q  <= SEND;
            end else begin
              gnt_err_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else if (timer_q == TMR_W'(GNT_TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        SEND: begin
          if (tx_rdy) begin
            if (last_beat) state_q <= IDLE;
            else           beat_q  <= beat_q + 7'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Stray grants outside WAIT are flagged but never disturb the sequence.
      if (gnt_val && (state_q != WAIT)) gnt_err_q <= 1'b1;
    end
  end

  assign req_val  = (state_q == REQ);
  assign {req3, req2, req1, req0} = req_val ? pend_nz : 4'd0;
  assign wt0      = wt[0];
  assign wt1      = wt[1];
  assign wt2      = wt[2];
  assign wt3      = wt[3];
  assign gnt_busy = sending;
  assign tx_val   = sending;
  assign tx_ch    = sending ? ch_q : 2'd0;
  assign tx_sop   = sending && (beat_q == 7'd0);
  assign tx_eop   = sending && last_beat;
  assign gnt_err  = gnt_err_q;
  assign gnt_cnt0 = g_ch[0].cnt_q;
  assign gnt_cnt1 = g_ch[1].cnt_q;
  assign gnt_cnt2 = g_ch[2].cnt_q;
  assign gnt_cnt3 = g_ch[3].cnt_q;

endmodule

// File: tb/tb_wrr4_req_disp.sv
// Self-checking bench for wrr4_req_disp: expected beats are queued when a grant
// is issued and matched against the beats the DUT hands over.
module tb_wrr4_req_disp;

  localparam int BEAT_BYTES  = 64;
  localparam int PEND_W      = 8;
  localparam int CNT_W       = 32;
  localparam int GNT_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       pkt_push;
  logic [2:0]       mtu0, mtu1, mtu2, mtu3;
  logic             req_val, req0, req1, req2, req3;
  logic [4:0]       wt0, wt1, wt2, wt3;
  logic             gnt_val;
  logic [3:0]       gnt;
  logic             gnt_busy, tx_val, tx_rdy, tx_sop, tx_eop, gnt_err;
  logic [1:0]       tx_ch;
  logic [3:0]       pend_ovf;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1, gnt_cnt2, gnt_cnt3;

  always #5 clk = ~clk;

  wrr4_req_disp #(
    .BEAT_BYTES(BEAT_BYTES), .PEND_W(PEND_W), .CNT_W(CNT_W), .GNT_TIMEOUT(GNT_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pkt_push(pkt_push),
    .mtu0(mtu0), .mtu1(mtu1), .mtu2(mtu2), .mtu3(mtu3),
    .req_val(req_val), .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .wt0(wt0), .wt1(wt1), .wt2(wt2), .wt3(wt3),
    .gnt_val(gnt_val), .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
    .gnt_busy(gnt_busy), .tx_val(tx_val), .tx_rdy(tx_rdy), .tx_ch(tx_ch),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .gnt_err(gnt_err), .pend_ovf(pend_ovf),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .gnt_cnt2(gnt_cnt2), .gnt_cnt3(gnt_cnt3)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [4:0] exp_wt(input int code);
    int c;
    c = (code > 4) ? 4 : code;
    return 5'(16 >> c);
  endfunction

  function automatic int exp_beats(input int code);
    int n;
    n = 256 / BEAT_BYTES;
    for (int k = 0; k < ((code > 4) ? 4 : code); k++) n = n * 2;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pkt_push = 4'd0; gnt_val = 1'b0; gnt = 4'd0; tx_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (req_val === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Called while the DUT shows REQ: step into WAIT, then present the grant.
  task automatic grant(input logic [3:0] g);
    tick();
    gnt_val = 1'b1; gnt = g;
    tick();
    gnt_val = 1'b0; gnt = 4'd0;
  endtask

  task automatic expect_packet(input int ch, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back('{ch: 2'(ch), sop: (b == 0), eop: (b == n - 1)});
  endtask

  task automatic stream(input int budget, input bit toggle, input logic [3:0] push_mask,
                        output bit done, output int busy_n, output int unstable_n,
                        output int busy_bad_n);
    beat_t prev, cur;
    bit    prev_stall;
    done = 1'b0; busy_n = 0; unstable_n = 0; busy_bad_n = 0; prev_stall = 1'b0; prev = '0;
    for (int c = 0; c < budget && !done; c++) begin
      tx_rdy = toggle ? (c % 2 == 0) : 1'b1;
      cur = '{ch: tx_ch, sop: tx_sop, eop: tx_eop};
      if (gnt_busy !== tx_val) busy_bad_n++;
      if (gnt_busy === 1'b1) busy_n++;
      if (prev_stall && (cur !== prev)) unstable_n++;
      prev = cur;
      prev_stall = (tx_val === 1'b1) && !tx_rdy;
      if ((tx_val === 1'b1) && tx_rdy) begin
        obs_q.push_back(cur);
        if (tx_eop === 1'b1) begin
          pkt_push = push_mask;
          done = 1'b1;
        end
      end
      tick();
      pkt_push = 4'd0;
    end
    tx_rdy = 1'b0;
  endtask

  task automatic test_reset();
    int reqs;
    rst = 1'b1; pkt_push = 4'hf; gnt_val = 1'b0; gnt = 4'd0; tx_rdy = 1'b0;
    mtu0 = 3'd0; mtu1 = 3'd0; mtu2 = 3'd0; mtu3 = 3'd0;
    repeat (3) tick();
    checks++;
    if ({req_val, gnt_busy, tx_val, tx_sop, tx_eop, gnt_err} !== 6'd0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000", {req_val, gnt_busy, tx_val, tx_sop, tx_eop, gnt_err});
    end
    checks++;
    if ({req3, req2, req1, req0} !== 4'd0) begin
      failures++; $display("FAIL reset_req: got %b expected 0000", {req3, req2, req1, req0});
    end
    checks++;
    if ({wt3, wt2, wt1, wt0} !== 20'd0) begin
      failures++; $display("FAIL reset_wt: got %h expected 0", {wt3, wt2, wt1, wt0});
    end
    checks++;
    if (tx_ch !== 2'd0) begin
      failures++; $display("FAIL reset_tx_ch: got %0d expected 0", tx_ch);
    end
    checks++;
    if (pend_ovf !== 4'd0) begin
      failures++; $display("FAIL reset_pend_ovf: got %b expected 0000", pend_ovf);
    end
    checks++;
    if ({gnt_cnt3, gnt_cnt2, gnt_cnt1, gnt_cnt0} !== 128'd0) begin
      failures++; $display("FAIL reset_gnt_cnt: got %h expected 0", {gnt_cnt3, gnt_cnt2, gnt_cnt1, gnt_cnt0});
    end
    rst = 1'b0; pkt_push = 4'd0;
    reqs = 0;
    repeat (6) begin
      tick();
      if (req_val === 1'b1) reqs++;
    end
    checks++;
    if (reqs !== 0) begin
      failures++; $display("FAIL reset_push_ignored: got %0d requests expected 0", reqs);
    end
  endtask

  task automatic test_basic();
    bit    seen, ok, done;
    int    first_at, busy_n, unstable_n, busy_bad_n;
    beat_t e, o;
    do_reset();
    mtu0 = 3'd2; mtu1 = 3'd3; mtu2 = 3'd0; mtu3 = 3'd4;
    seen = 1'b0; first_at = -1;
    for (int i = 0; i < 10; i++) begin
      pkt_push = 4'hf;
      tick();
      if (!seen && (req_val === 1'b1)) begin
        seen = 1'b1; first_at = i;
        checks++;
        if ({req3, req2, req1, req0} !== 4'b1111) begin
          failures++; $display("FAIL basic_req: got %b expected 1111", {req3, req2, req1, req0});
        end
        checks++;
        if ({wt3, wt2, wt1, wt0} !== {exp_wt(4), exp_wt(0), exp_wt(3), exp_wt(2)}) begin
          failures++;
          $display("FAIL basic_wt: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", wt0, wt1, wt2, wt3,
                   exp_wt(2), exp_wt(3), exp_wt(0), exp_wt(4));
        end
      end
    end
    pkt_push = 4'd0;
    checks++;
    if (first_at !== 1) begin
      failures++; $display("FAIL basic_req_latency: got sample %0d expected 1", first_at);
    end
    wait_req(60, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL basic_rereq: got no req_val expected req_val within 60 cycles");
    end
    expect_packet(2, exp_beats(0));
    grant(4'b0100);
    stream(40, 1'b0, 4'd0, done, busy_n, unstable_n, busy_bad_n);
    checks++;
    if (!done) begin
      failures++; $display("FAIL basic_eop_timeout: got no eop expected eop within 40 cycles");
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_beat: got ch=%0d sop=%0b eop=%0b expected ch=%0d sop=%0b eop=%0b",
                 o.ch, o.sop, o.eop, e.ch, e.sop, e.eop);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (busy_n !== 4 || busy_bad_n !== 0) begin
      failures++; $display("FAIL basic_busy: got %0d cycles (%0d mismatched) expected 4 (0)", busy_n, busy_bad_n);
    end
    checks++;
    if ({gnt_busy, tx_val} !== 2'b00) begin
      failures++; $display("FAIL basic_busy_fall: got %b expected 00", {gnt_busy, tx_val});
    end
    checks++;
    if ({gnt_cnt3, gnt_cnt2, gnt_cnt1, gnt_cnt0} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
      failures++; $display("FAIL basic_gnt_cnt: got %0d/%0d/%0d/%0d expected 0/0/1/0", gnt_cnt0, gnt_cnt1, gnt_cnt2, gnt_cnt3);
    end
    tick();
    checks++;
    if (req_val !== 1'b1) begin
      failures++; $display("FAIL back_to_back_req: got %b expected 1", req_val);
    end
  endtask

  task automatic test_stall();
    bit    ok, done;
    int    busy_n, unstable_n, busy_bad_n, n;
    beat_t e, o;
    wait_req(40, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL stall_req: got no req_val expected req_val within 40 cycles");
    end
    n = exp_beats(4);
    expect_packet(3, n);
    grant(4'b1000);
    stream(400, 1'b1, 4'd0, done, busy_n, unstable_n, busy_bad_n);
    checks++;
    if (!done) begin
      failures++; $display("FAIL stall_eop_timeout: got no eop expected eop within 400 cycles");
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL stall_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall_beat: got ch=%0d sop=%0b eop=%0b expected ch=%0d sop=%0b eop=%0b",
                 o.ch, o.sop, o.eop, e.ch, e.sop, e.eop);
      end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (unstable_n !== 0) begin
      failures++; $display("FAIL stall_stable: got %0d changes under stall expected 0", unstable_n);
    end
    checks++;
    if (busy_n !== 2 * n - 1 || busy_bad_n !== 0) begin
      failures++; $display("FAIL stall_busy: got %0d cycles (%0d mismatched) expected %0d (0)", busy_n, busy_bad_n, 2 * n - 1);
    end
    checks++;
    if (gnt_cnt3 !== 32'd1) begin
      failures++; $display("FAIL stall_gnt_cnt3: got %0d expected 1", gnt_cnt3);
    end
  endtask

  task automatic test_push_eop();
    bit    ok, done;
    int    busy_n, unstable_n, busy_bad_n;
    beat_t e, o;
    do_reset();
    mtu1 = 3'd0;
    pkt_push = 4'b0010; tick(); pkt_push = 4'd0;
    for (int pass = 0; pass < 2; pass++) begin
      wait_req(20, ok);
      checks++;
      if (!ok || ({req3, req2, req1, req0} !== 4'b0010)) begin
        failures++; $display("FAIL push_eop_req%0d: got ok=%0b req=%b expected ok=1 req=0010", pass, ok, {req3, req2, req1, req0});
      end
      expect_packet(1, exp_beats(0));
      grant(4'b0010);
      stream(40, 1'b0, (pass == 0) ? 4'b0010 : 4'b0000, done, busy_n, unstable_n, busy_bad_n);
      checks++;
      if (!done || (obs_q.size() != exp_q.size())) begin
        failures++; $display("FAIL push_eop_beats%0d: got done=%0b n=%0d expected done=1 n=%0d", pass, done, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL push_eop_beat: got ch=%0d sop=%0b eop=%0b expected ch=%0d sop=%0b eop=%0b",
                   o.ch, o.sop, o.eop, e.ch, e.sop, e.eop);
        end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (gnt_cnt1 !== 32'(pass + 1)) begin
        failures++; $display("FAIL push_eop_gnt_cnt1: got %0d expected %0d", gnt_cnt1, pass + 1);
      end
    end
    wait_req(25, ok);
    checks++;
    if (ok) begin
      failures++; $display("FAIL push_eop_drained: got req_val expected none after queue drained");
    end
  endtask

  task automatic test_sat();
    bit ok;
    do_reset();
    mtu0 = 3'd0;
    for (int i = 0; i < 255; i++) begin
      pkt_push = 4'b0001; tick();
    end
    pkt_push = 4'd0;
    tick();
    checks++;
    if (pend_ovf !== 4'b0000) begin
      failures++; $display("FAIL sat_no_ovf_at_255: got %b expected 0000", pend_ovf);
    end
    pkt_push = 4'b0001; tick(); pkt_push = 4'd0;
    checks++;
    if (pend_ovf !== 4'b0001) begin
      failures++; $display("FAIL sat_ovf: got %b expected 0001", pend_ovf);
    end
    wait_req(40, ok);
    checks++;
    if (!ok || req0 !== 1'b1) begin
      failures++; $display("FAIL sat_count_held: got ok=%0b req0=%b expected ok=1 req0=1", ok, req0);
    end
    checks++;
    if (gnt_err !== 1'b0) begin
      failures++; $display("FAIL sat_gnt_err: got %b expected 0", gnt_err);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int first_req, beats;
    for (int c = 0; c < 4; c++) begin
      do_reset();
      if (c < 3) begin
        pkt_push = 4'b0011; tick(); pkt_push = 4'd0;
        wait_req(10, ok);
        checks++;
        if (!ok || ({req3, req2, req1, req0} !== 4'b0011)) begin
          failures++; $display("FAIL illegal_req%0d: got ok=%0b req=%b expected ok=1 req=0011", c, ok, {req3, req2, req1, req0});
        end
        tick();
        gnt_val = 1'b1;
        gnt = (c == 0) ? 4'b0011 : ((c == 1) ? 4'b0000 : 4'b0100);
      end else begin
        gnt_val = 1'b1; gnt = 4'b0001;
      end
      tick();
      gnt_val = 1'b0; gnt = 4'd0;
      checks++;
      if (gnt_err !== 1'b1) begin
        failures++; $display("FAIL illegal_err%0d: got %b expected 1", c, gnt_err);
      end
      first_req = -1; beats = 0;
      for (int j = 0; j < 20; j++) begin
        if ((tx_val === 1'b1) || (gnt_busy === 1'b1)) beats++;
        if ((first_req < 0) && (req_val === 1'b1)) first_req = j;
        tick();
      end
      checks++;
      if (beats !== 0) begin
        failures++; $display("FAIL illegal_beats%0d: got %0d busy cycles expected 0", c, beats);
      end
      checks++;
      if (first_req !== ((c < 3) ? 1 : -1)) begin
        failures++; $display("FAIL illegal_idle%0d: got req at %0d expected %0d", c, first_req, (c < 3) ? 1 : -1);
      end
    end
  endtask

  task automatic test_timeout();
    int gap;
    bit stray;
    do_reset();
    mtu3 = 3'd6;
    pkt_push = 4'b1000; tick(); pkt_push = 4'd0;
    checks++;
    if (req_val !== 1'b0) begin
      failures++; $display("FAIL timeout_latency_t1: got req_val=%b expected 0", req_val);
    end
    tick();
    checks++;
    if ((req_val !== 1'b1) || ({req3, req2, req1, req0} !== 4'b1000) || (wt3 !== exp_wt(6))) begin
      failures++; $display("FAIL timeout_first_req: got val=%b req=%b wt3=%0d expected 1 1000 %0d", req_val, {req3, req2, req1, req0}, wt3, exp_wt(6));
    end
    gap = -1; stray = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((gnt_busy === 1'b1) || (gnt_err === 1'b1)) stray = 1'b1;
      if (req_val === 1'b1) begin
        gap = i;
        break;
      end
    end
    checks++;
    if (gap !== GNT_TIMEOUT + 2) begin
      failures++; $display("FAIL timeout_rereq: got gap %0d expected %0d", gap, GNT_TIMEOUT + 2);
    end
    checks++;
    if (stray) begin
      failures++; $display("FAIL timeout_flags: got busy/err during WAIT expected none");
    end
  endtask

  task automatic test_rst_abort();
    bit ok;
    do_reset();
    mtu2 = 3'd2;
    pkt_push = 4'b0100; tick(); pkt_push = 4'd0;
    wait_req(10, ok);
    grant(4'b0100);
    tx_rdy = 1'b1;
    repeat (5) tick();
    checks++;
    if ((tx_val !== 1'b1) || (tx_sop !== 1'b0) || (tx_eop !== 1'b0)) begin
      failures++; $display("FAIL abort_beat5: got val=%b sop=%b eop=%b expected 1 0 0", tx_val, tx_sop, tx_eop);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({req_val, gnt_busy, tx_val, tx_sop, tx_eop, gnt_err, tx_ch} !== 8'd0) begin
      failures++; $display("FAIL abort_outputs: got %b expected 00000000", {req_val, gnt_busy, tx_val, tx_sop, tx_eop, gnt_err, tx_ch});
    end
    checks++;
    if ((gnt_cnt2 !== 32'd0) || (pend_ovf !== 4'd0)) begin
      failures++; $display("FAIL abort_counters: got cnt2=%0d ovf=%b expected 0 0000", gnt_cnt2, pend_ovf);
    end
    rst = 1'b0; tx_rdy = 1'b0;
    wait_req(15, ok);
    checks++;
    if (ok) begin
      failures++; $display("FAIL abort_pend_cleared: got req_val expected none");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_push_eop();
    test_sat();
    test_illegal();
    test_timeout();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
